// File: rtl/layered_drawing_mux.sv
// rtl/layered_drawing_mux.sv - N-layer priority pixel mux with frame-synced layer mask and collision flags
// Registered outputs appear one clock after the inputs; mask and collision state change only at frame start.
module layered_drawing_mux #(
  parameter int               NUM_LAYERS  = 8,
  parameter int               RGB_W       = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT = 8'hFF,
  parameter logic [RGB_W-1:0] BG_RGB      = 8'h00,
  localparam int              ID_W        = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic [NUM_LAYERS-1:0]       drawRequest,
  input  logic [NUM_LAYERS*RGB_W-1:0] rgbIn,
  input  logic                        startOfFrame,
  input  logic                        maskLoad,
  input  logic [NUM_LAYERS-1:0]       maskIn,
  output logic                        drawRequestOut,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [ID_W-1:0]             layerIdOut,
  output logic                        collisionOut,
  output logic [NUM_LAYERS-1:0]       frameCollision,
  output logic                        maskPending
);

  logic                  draw_q, coll_q, pend_flag_q;
  logic [RGB_W-1:0]      rgb_q;
  logic [ID_W-1:0]       id_q;
  logic [NUM_LAYERS-1:0] frame_coll_q, sticky_q, active_mask_q, pending_mask_q;

  logic [NUM_LAYERS-1:0] eff;
  logic                  win_found, multi;
  logic [ID_W-1:0]       win_id;
  logic [RGB_W-1:0]      win_rgb;

  // Scan from layer 0 so the first hit is the winner; any later hit means a collision.
  always_comb begin
    eff       = '0;
    win_found = 1'b0;
    multi     = 1'b0;
    win_id    = '0;
    win_rgb   = BG_RGB;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff[i] = drawRequest[i] & active_mask_q[i] &
               (rgbIn[i*RGB_W +: RGB_W] != TRANSPARENT);
      if (eff[i]) begin
        if (win_found) begin
          multi = 1'b1;
        end else begin
          win_found = 1'b1;
          win_id    = ID_W'(i);
          win_rgb   = rgbIn[i*RGB_W +: RGB_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_q         <= 1'b0;
      rgb_q          <= BG_RGB;
      id_q           <= '0;
      coll_q         <= 1'b0;
      frame_coll_q   <= '0;
      sticky_q       <= '0;
      active_mask_q  <= '1;
      pending_mask_q <= '1;
      pend_flag_q    <= 1'b0;
    end else begin
      draw_q <= win_found;
      rgb_q  <= win_rgb;
      id_q   <= win_id;
      coll_q <= multi;
      if (startOfFrame) begin
        // The SOF pixel already belongs to the new frame's collision record.
        frame_coll_q <= sticky_q;
        sticky_q     <= multi ? eff : '0;
        if (maskLoad) begin
          active_mask_q  <= maskIn;
          pending_mask_q <= maskIn;
          pend_flag_q    <= 1'b0;
        end else if (pend_flag_q) begin
          active_mask_q <= pending_mask_q;
          pend_flag_q   <= 1'b0;
        end
      end else begin
        if (multi) begin
          sticky_q <= sticky_q | eff;
        end
        if (maskLoad) begin
          pending_mask_q <= maskIn;
          pend_flag_q    <= 1'b1;
        end
      end
    end
  end

  assign drawRequestOut = draw_q;
  assign RGBOut         = rgb_q;
  assign layerIdOut     = id_q;
  assign collisionOut   = coll_q;
  assign frameCollision = frame_coll_q;
  assign maskPending    = pend_flag_q;

endmodule
